oserdes_word_scheduler: RTL and testbench

Core-clock controller in front of one O_SERDES output lane. It waits for a stable PLL lock, then shares the lane between two valid/ready word requesters using round-robin arbitration. It drives the serializer's parallel word, LOAD_WORD and OE every cycle, and sequences the DLY_ADJ/DLY_INCDEC taps to reach a requested output delay.

---
 rtl/oserdes_word_scheduler.sv | 103 ++++++++++
 tb/tb_oserdes_word_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/oserdes_word_scheduler.sv
// oserdes_word_scheduler: lock-gated round-robin word feed and delay-tap sequencer for one O_SERDES lane.
// Define OSERDES_SCHED_DLY_EN to build the DLY_ADJ/DLY_INCDEC tap sequencer; otherwise those outputs are tied low.
module oserdes_word_scheduler #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0,
  parameter int LOCK_WAIT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pll_lock,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             dly_target_valid,
  input  logic [5:0]       dly_target,
  input  logic [5:0]       dly_tap_value,
  output logic             dly_busy,
  output logic [WIDTH-1:0] serdes_d,
  output logic             serdes_load_word,
  output logic             serdes_oe,
  output logic             serdes_dly_adj,
  output logic             serdes_dly_incdec,
  output logic             serdes_dly_load,
  output logic             link_up
);
  typedef enum logic {WAIT_LOCK, RUN} link_t;
  link_t link_st;
  logic [7:0] lock_cnt;
  logic prio;
  logic run;
  assign run = link_st == RUN;
  assign link_up = run;
  assign serdes_load_word = run;
  assign serdes_oe = run;
  assign serdes_dly_load = 1'b0;
  // prio=1 means req1 wins the next tie
  assign req0_ready = run && req0_valid && (!req1_valid || !prio);
  assign req1_ready = run && req1_valid && (!req0_valid || prio);
  always_ff @(posedge clock) begin
    if (reset) begin
      link_st <= WAIT_LOCK;
      lock_cnt <= 8'd0;
      prio <= 1'b0;
      serdes_d <= IDLE_WORD;
    end else begin
      serdes_d <= req0_ready ? req0_data : req1_ready ? req1_data : IDLE_WORD;
      prio <= req0_ready ? 1'b1 : req1_ready ? 1'b0 : prio;
      if (!run) begin
        lock_cnt <= pll_lock ? lock_cnt + 8'd1 : 8'd0;
        link_st <= pll_lock && lock_cnt == 8'(LOCK_WAIT - 1) ? RUN : WAIT_LOCK;
      end else if (!pll_lock) begin
        link_st <= WAIT_LOCK;
        lock_cnt <= 8'd0;
      end
    end
  end
`ifdef OSERDES_SCHED_DLY_EN
  typedef enum logic [1:0] {D_IDLE, D_STEP, D_SETTLE} dly_t;
  dly_t dly_st;
  logic [5:0] target;
  logic settle;
  assign dly_busy = dly_st != D_IDLE;
  // adj/incdec are registered, so the pulse lands in the first settle cycle
  always_ff @(posedge clock) begin
    if (reset || (run && !pll_lock)) begin
      dly_st <= D_IDLE;
      target <= reset ? 6'd0 : target;
      settle <= 1'b0;
      serdes_dly_adj <= 1'b0;
      serdes_dly_incdec <= 1'b0;
    end else begin
      serdes_dly_adj <= 1'b0;
      serdes_dly_incdec <= 1'b0;
      case (dly_st)
        D_IDLE: begin
          target <= dly_target_valid ? dly_target : target;
          dly_st <= dly_target_valid ? D_STEP : D_IDLE;
        end
        D_STEP: begin
          serdes_dly_adj <= dly_tap_value != target;
          serdes_dly_incdec <= dly_tap_value < target;
          settle <= 1'b0;
          dly_st <= dly_tap_value == target ? D_IDLE : D_SETTLE;
        end
        D_SETTLE: begin
          settle <= 1'b1;
          dly_st <= settle ? D_STEP : D_SETTLE;
        end
        default: dly_st <= D_IDLE;
      endcase
    end
  end
`else
  logic unused_dly;
  assign unused_dly = ^{dly_target_valid, dly_target, dly_tap_value};
  assign dly_busy = 1'b0;
  assign serdes_dly_adj = 1'b0;
  assign serdes_dly_incdec = 1'b0;
`endif
endmodule

// File: tb/tb_oserdes_word_scheduler.sv
// tb_oserdes_word_scheduler: directed checks of lock, arbitration, idle fill, delay stepping, lock loss and reset.
module tb_oserdes_word_scheduler;
  localparam int W = 4;
`ifdef OSERDES_SCHED_DLY_EN
  localparam bit DLY_EN = 1'b1;
`else
  localparam bit DLY_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset, pll_lock, req0_valid, req1_valid, dly_target_valid;
  logic [W-1:0] req0_data, req1_data, serdes_d;
  logic req0_ready, req1_ready, dly_busy, serdes_load_word, serdes_oe;
  logic serdes_dly_adj, serdes_dly_incdec, serdes_dly_load, link_up;
  logic [5:0] dly_target;
  logic [5:0] tap = 6'd0;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // tap model: each adj pulse moves the tap one step, visible the following cycle
  always @(posedge clock) if (serdes_dly_adj) tap <= serdes_dly_incdec ? tap + 6'd1 : tap - 6'd1;

  oserdes_word_scheduler #(.WIDTH(W), .IDLE_WORD(4'h0), .LOCK_WAIT(16)) dut (
    .clock(clock), .reset(reset), .pll_lock(pll_lock),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .dly_target_valid(dly_target_valid), .dly_target(dly_target), .dly_tap_value(tap),
    .dly_busy(dly_busy), .serdes_d(serdes_d), .serdes_load_word(serdes_load_word),
    .serdes_oe(serdes_oe), .serdes_dly_adj(serdes_dly_adj), .serdes_dly_incdec(serdes_dly_incdec),
    .serdes_dly_load(serdes_dly_load), .link_up(link_up)
  );

  task automatic test_reset;
    reset = 1; pll_lock = 1; req0_valid = 1; req1_valid = 1; req0_data = 4'hA; req1_data = 4'h5;
    dly_target_valid = 1; dly_target = 6'd9;
    repeat (2) @(negedge clock);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready}); end
    checks++;
    if (serdes_d !== 4'h0) begin errors++; $display("FAIL reset_d got %h exp 0", serdes_d); end
    checks++;
    if ({serdes_load_word, serdes_oe, link_up, serdes_dly_adj, serdes_dly_incdec, serdes_dly_load, dly_busy} !== 7'b0)
      begin errors++; $display("FAIL reset_ctl got %b exp 0000000", {serdes_load_word, serdes_oe, link_up, serdes_dly_adj, serdes_dly_incdec, serdes_dly_load, dly_busy}); end
    reset = 0; pll_lock = 0; req0_valid = 0; req1_valid = 0; dly_target_valid = 0;
  endtask

  task automatic test_lock;
    pll_lock = 1;
    repeat (10) @(negedge clock);
    pll_lock = 0;
    @(negedge clock);
    pll_lock = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      checks++;
      if ({link_up, serdes_oe, serdes_load_word} !== 3'b000) begin errors++; $display("FAIL lock_early cyc %0d got %b exp 000", i, {link_up, serdes_oe, serdes_load_word}); end
    end
    @(negedge clock);
    checks++;
    if ({link_up, serdes_oe, serdes_load_word} !== 3'b111) begin errors++; $display("FAIL lock_up got %b exp 111", {link_up, serdes_oe, serdes_load_word}); end
  endtask

  task automatic test_arbitration;
    logic g;
    req0_data = 4'hA; req1_data = 4'h5; req0_valid = 1; req1_valid = 1;
    g = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== {!g, g}) begin errors++; $display("FAIL arb_grant %0d got %b exp %b", i, {req0_ready, req1_ready}, {!g, g}); end
      @(negedge clock);
      checks++;
      if (serdes_d !== (g ? 4'h5 : 4'hA)) begin errors++; $display("FAIL arb_data %0d got %h exp %h", i, serdes_d, g ? 4'h5 : 4'hA); end
      g = !g;
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({serdes_load_word, serdes_d} !== {1'b1, 4'h0}) begin errors++; $display("FAIL idle_fill %0d got %b_%h exp 1_0", i, serdes_load_word, serdes_d); end
    end
    req1_data = 4'h3; req1_valid = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL idle_grant got %b exp 01", {req0_ready, req1_ready}); end
    @(negedge clock);
    req1_valid = 0;
    checks++;
    if (serdes_d !== 4'h3) begin errors++; $display("FAIL idle_word got %h exp 3", serdes_d); end
    @(negedge clock);
    checks++;
    if (serdes_d !== 4'h0) begin errors++; $display("FAIL idle_after got %h exp 0", serdes_d); end
  endtask

  task automatic test_delay;
    logic p;
    dly_target = 6'd3; dly_target_valid = 1;
    @(negedge clock);
    dly_target_valid = 0;
    for (int c = 0; c <= 10; c++) begin
      p = (c == 1 || c == 4 || c == 7);
      checks++;
      if ({serdes_dly_adj, serdes_dly_incdec, dly_busy} !== (DLY_EN ? {p, p, c < 10} : 3'b000))
        begin errors++; $display("FAIL dly_up c%0d got %b exp %b", c, {serdes_dly_adj, serdes_dly_incdec, dly_busy}, DLY_EN ? {p, p, c < 10} : 3'b000); end
      if (c < 10) @(negedge clock);
    end
    dly_target = 6'd1; dly_target_valid = 1;
    @(negedge clock);
    dly_target_valid = 0;
    for (int c = 0; c <= 7; c++) begin
      p = (c == 1 || c == 4);
      checks++;
      if ({serdes_dly_adj, serdes_dly_incdec, dly_busy} !== (DLY_EN ? {p, 1'b0, c < 7} : 3'b000))
        begin errors++; $display("FAIL dly_dn c%0d got %b exp %b", c, {serdes_dly_adj, serdes_dly_incdec, dly_busy}, DLY_EN ? {p, 1'b0, c < 7} : 3'b000); end
      if (c < 7) @(negedge clock);
    end
    checks++;
    if (tap !== (DLY_EN ? 6'd1 : 6'd0)) begin errors++; $display("FAIL dly_tap got %0d exp %0d", tap, DLY_EN ? 1 : 0); end
  endtask

  task automatic test_lock_loss;
    req0_data = 4'hA; req1_data = 4'h5; req0_valid = 1; req1_valid = 1;
    dly_target = 6'd5; dly_target_valid = 1;
    @(negedge clock);
    dly_target_valid = 0;
    for (int c = 0; c <= 2; c++) begin
      checks++;
      if ({serdes_d, dly_busy, serdes_dly_adj} !== {(c == 1) ? 4'h5 : 4'hA, DLY_EN, DLY_EN && c == 1})
        begin errors++; $display("FAIL loss_pre c%0d got %h_%b%b exp %h_%b%b", c, serdes_d, dly_busy, serdes_dly_adj, (c == 1) ? 4'h5 : 4'hA, DLY_EN, DLY_EN && c == 1); end
      if (c < 2) @(negedge clock);
    end
    pll_lock = 0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL loss_last_grant got %b exp 01", {req0_ready, req1_ready}); end
    @(negedge clock);
    #1;
    checks++;
    if ({req0_ready, req1_ready, serdes_load_word, serdes_oe, link_up, dly_busy, serdes_dly_adj} !== 7'b0)
      begin errors++; $display("FAIL loss_ctl got %b exp 0000000", {req0_ready, req1_ready, serdes_load_word, serdes_oe, link_up, dly_busy, serdes_dly_adj}); end
    checks++;
    if (serdes_d !== 4'h5) begin errors++; $display("FAIL loss_final_word got %h exp 5", serdes_d); end
    req0_valid = 0; req1_valid = 0; pll_lock = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      checks++;
      if ({link_up, serdes_dly_adj, dly_busy, serdes_d} !== 7'b0) begin errors++; $display("FAIL relock_wait %0d got %b exp 0000000", i, {link_up, serdes_dly_adj, dly_busy, serdes_d}); end
    end
    @(negedge clock);
    checks++;
    if (link_up !== 1'b1) begin errors++; $display("FAIL relock_up got %b exp 1", link_up); end
  endtask

  task automatic test_reset_mid;
    req0_data = 4'hA; req1_data = 4'h5; req0_valid = 1; req1_valid = 1;
    dly_target = 6'd6; dly_target_valid = 1;
    @(negedge clock);
    dly_target_valid = 0;
    for (int c = 0; c <= 2; c++) begin
      checks++;
      if ({serdes_d, dly_busy} !== {(c == 1) ? 4'h5 : 4'hA, DLY_EN})
        begin errors++; $display("FAIL rmid_pre c%0d got %h_%b exp %h_%b", c, serdes_d, dly_busy, (c == 1) ? 4'h5 : 4'hA, DLY_EN); end
      if (c < 2) @(negedge clock);
    end
    reset = 1;
    @(negedge clock);
    #1;
    checks++;
    if ({req0_ready, req1_ready, serdes_d, serdes_load_word, serdes_oe, link_up, serdes_dly_adj, serdes_dly_incdec, serdes_dly_load, dly_busy} !== 13'b0)
      begin errors++; $display("FAIL rmid_reset got %b exp 0", {req0_ready, req1_ready, serdes_d, serdes_load_word, serdes_oe, link_up, serdes_dly_adj, serdes_dly_incdec, serdes_dly_load, dly_busy}); end
    reset = 0;
    repeat (15) @(negedge clock);
    checks++;
    if (link_up !== 1'b0) begin errors++; $display("FAIL rmid_early got %b exp 0", link_up); end
    @(negedge clock);
    #1;
    checks++;
    if ({link_up, req0_ready, req1_ready} !== 3'b110) begin errors++; $display("FAIL rmid_prio got %b exp 110", {link_up, req0_ready, req1_ready}); end
    @(negedge clock);
    checks++;
    if (serdes_d !== 4'hA) begin errors++; $display("FAIL rmid_word got %h exp a", serdes_d); end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_arbitration();
    test_idle();
    test_delay();
    test_lock_loss();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
